// File: rtl/spart_pkg.sv
// Shared SPART definitions.
// Contents:
//   - rx_state_t: receiver FSM states.
//   - OVERSAMPLE_DEF / DATA_BITS_DEF: defaults shared with the transmitter
//     and the baud generator.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side view of the SPART receiver.
// Signals:
//   clr_rda     - one-clock pulse from the bus; the byte has been read.
//   RxD_data    - last received byte.
//   RDA         - received data available.
//   framing_err - stop bit of the last byte sampled low.
//   overrun_err - a byte completed while RDA was still set.
// Modports:
//   master - the bus reader.
//   slave  - the receiver.
interface spart_rx_if
  import spart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic                 clr_rda;
  logic [DATA_BITS-1:0] RxD_data;
  logic                 RDA;
  logic                 framing_err;
  logic                 overrun_err;

  modport master (
    output clr_rda,
    input  RxD_data, RDA, framing_err, overrun_err
  );

  modport slave (
    input  clr_rda,
    output RxD_data, RDA, framing_err, overrun_err
  );
endinterface

// File: rtl/spart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain and flags
// falling edges.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset.
//   rxd        - raw serial line (asynchronous).
//   rxd_s      - synchronised line level.
//   start_edge - high for one clock when rxd_s has just fallen.
module spart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic start_edge
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Line idles high, so the synchroniser resets to 1 and no edge is
  // reported coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= rxd;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rxd_s      = sync_reg;
  // Edge rather than level, so a held-low break does not restart reception.
  assign start_edge = prev_reg & ~sync_reg;

endmodule

// File: rtl/spart_rx.sv
// SPART receive path: deserialises an 8N1 line paced by the oversample
// tick (Enable) into bytes with RDA, framing and overrun flags.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset.
//   Enable     - one-clock oversample tick, OVERSAMPLE ticks per bit.
//   RxD        - serial line, idle high, asynchronous to clk.
//   bus        - bus-side signals (clr_rda in; RxD_data, RDA, flags out).
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      Enable,
  input  logic      RxD,
  spart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxd_s;
  logic start_edge;

  rx_state_t            state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 rda_reg, rda_next;
  logic                 ferr_reg, ferr_next;
  logic                 oerr_reg, oerr_next;

  spart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (RxD),
    .rxd_s      (rxd_s),
    .start_edge (start_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      rda_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
      oerr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      rda_reg      <= rda_next;
      ferr_reg     <= ferr_next;
      oerr_reg     <= oerr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    rda_next      = rda_reg;
    ferr_next     = ferr_reg;
    oerr_next     = oerr_reg;

    // A bus read clears the flags; a frame completing on the same clock
    // overrides this below.
    if (bus.clr_rda) begin
      rda_next  = 1'b0;
      ferr_next = 1'b0;
      oerr_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end

      START: begin
        if (Enable) begin
          if (tick_cnt_reg == TICK_MID) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            // Line back high at mid start bit: treat as a glitch.
            state_next    = rxd_s ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (Enable) begin
          if (tick_cnt_reg == TICK_LAST) begin
            shift_next    = {rxd_s, shift_reg[DATA_BITS-1:1]};
            tick_cnt_next = '0;
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (Enable) begin
          if (tick_cnt_reg == TICK_LAST) begin
            data_next     = shift_reg;
            rda_next      = 1'b1;
            ferr_next     = ~rxd_s;
            // Unread byte overwritten, unless it is being read right now.
            if (rda_reg && !bus.clr_rda) begin
              oerr_next = 1'b1;
            end
            tick_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.RxD_data    = data_reg;
  assign bus.RDA         = rda_reg;
  assign bus.framing_err = ferr_reg;
  assign bus.overrun_err = oerr_reg;

endmodule
